// File: rtl/simt_core_sequencer_if.sv
// Core-side bus of the SIMT sequencer: fetch handshake, decoded instruction class,
// per-lane ALU flags, LSU requests/completions and register-file write strobes.
interface simt_core_sequencer_if #(
  parameter int THREADS_PER_BLOCK     = 4,
  parameter int PROGRAM_MEM_ADDR_BITS = 8
);
  logic                               fetch_enable;
  logic                               fetch_done;
  logic                               is_alu;
  logic                               is_cmp;
  logic                               is_const;
  logic                               is_ldr;
  logic                               is_str;
  logic                               is_branch;
  logic                               is_halt;
  logic [2:0]                         condition;
  logic [PROGRAM_MEM_ADDR_BITS-1:0]   branch_target;
  logic [3*THREADS_PER_BLOCK-1:0]     alu_nzp;
  logic [THREADS_PER_BLOCK-1:0]       lsu_load_enable;
  logic [THREADS_PER_BLOCK-1:0]       lsu_store_enable;
  logic [THREADS_PER_BLOCK-1:0]       lsu_done;
  logic [THREADS_PER_BLOCK-1:0]       reg_write_enable;
  logic [1:0]                         reg_write_sel;

  modport master (
    output fetch_enable, lsu_load_enable, lsu_store_enable, reg_write_enable, reg_write_sel,
    input  fetch_done, is_alu, is_cmp, is_const, is_ldr, is_str, is_branch, is_halt,
           condition, branch_target, alu_nzp, lsu_done
  );

  modport slave (
    input  fetch_enable, lsu_load_enable, lsu_store_enable, reg_write_enable, reg_write_sel,
    output fetch_done, is_alu, is_cmp, is_const, is_ldr, is_str, is_branch, is_halt,
           condition, branch_target, alu_nzp, lsu_done
  );
endinterface

// File: rtl/simt_core_sequencer.sv
// Per-core control sequencer: owns PC, per-lane NZP flags and the active mask, steps each
// instruction through fetch/decode/mem/execute/update, detects branch divergence and runs a watchdog.
module simt_core_sequencer #(
  parameter int THREADS_PER_BLOCK     = 4,
  parameter int PROGRAM_MEM_ADDR_BITS = 8,
  parameter int WATCHDOG_CYCLES       = 1023
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  start,
  input  logic [$clog2(THREADS_PER_BLOCK):0]    thread_count,
  output logic                                  done,
  output logic                                  timeout,
  output logic                                  diverged,
  output logic [THREADS_PER_BLOCK-1:0]          active_threads,
  output logic [PROGRAM_MEM_ADDR_BITS-1:0]      pc,
  simt_core_sequencer_if.master                 core
);
  localparam int T    = THREADS_PER_BLOCK;
  localparam int A    = PROGRAM_MEM_ADDR_BITS;
  localparam int TC_W = $clog2(THREADS_PER_BLOCK) + 1;
  localparam int WD_W = $clog2(WATCHDOG_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(WATCHDOG_CYCLES);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_MEM, S_EXECUTE, S_UPDATE, S_DONE
  } state_e;

  // Decoded class captured in DECODE so later phases do not depend on the decoder holding still.
  typedef struct packed {
    logic         alu;
    logic         cmp;
    logic         cnst;
    logic         ldr;
    logic         str;
    logic         branch;
    logic [2:0]   cond;
    logic [A-1:0] target;
  } instr_t;

  state_e              state_q, state_d;
  instr_t              instr_q, instr_d;
  logic [A-1:0]        pc_q, pc_d;
  logic [T-1:0][2:0]   nzp_q, nzp_d;
  logic [WD_W-1:0]     wd_q, wd_d;
  logic                timeout_q, timeout_d;
  logic                diverged_q, diverged_d;

  logic                running;
  logic                expired;
  logic                mem_ready;
  logic [T-1:0]        lane_agree;
  logic [T-1:0]        agree_active;
  logic                branch_take;
  logic                branch_mixed;

  always_comb begin
    for (int t = 0; t < T; t++) begin
      active_threads[t] = (thread_count > TC_W'(t));
    end
  end

  assign running   = (state_q != S_IDLE) && (state_q != S_DONE);
  assign expired   = running && (wd_q >= WD_LIMIT);
  assign mem_ready = ((core.lsu_done & active_threads) == active_threads);

  always_comb begin
    for (int t = 0; t < T; t++) begin
      lane_agree[t] = |(nzp_q[t] & instr_q.cond);
    end
  end

  assign agree_active = lane_agree & active_threads;
  // An empty mask never takes the branch: it falls through like "no lane agrees".
  assign branch_take  = (active_threads != '0) && (agree_active == active_threads);
  assign branch_mixed = (agree_active != '0) && (agree_active != active_threads);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // NOTE: every combinational output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    if (expired) begin
      state_d = S_DONE;
    end else begin
      case (state_q)
        S_IDLE:    if (start) state_d = S_FETCH;
        S_FETCH:   if (core.fetch_done) state_d = S_DECODE;
        S_DECODE: begin
          if (core.is_halt)                   state_d = S_DONE;
          else if (core.is_ldr || core.is_str) state_d = S_MEM;
          else                                 state_d = S_EXECUTE;
        end
        S_MEM:     if (mem_ready) state_d = S_EXECUTE;
        S_EXECUTE: state_d = S_UPDATE;
        S_UPDATE:  state_d = S_FETCH;
        S_DONE:    if (!start) state_d = S_IDLE;
        default:   state_d = S_IDLE;
      endcase
    end
  end

  // The expiry cycle suppresses every strobe so a timeout pre-empts a pending write or request.
  always_comb begin
    core.fetch_enable     = 1'b0;
    core.lsu_load_enable  = '0;
    core.lsu_store_enable = '0;
    core.reg_write_enable = '0;
    core.reg_write_sel    = 2'd0;
    if (!expired) begin
      case (state_q)
        S_FETCH: core.fetch_enable = 1'b1;
        S_MEM: begin
          core.lsu_load_enable  = instr_q.ldr ? active_threads : '0;
          core.lsu_store_enable = instr_q.str ? active_threads : '0;
        end
        S_EXECUTE: begin
          if (instr_q.alu || instr_q.cnst || instr_q.ldr) core.reg_write_enable = active_threads;
          if (instr_q.ldr)       core.reg_write_sel = 2'd1;
          else if (instr_q.cnst) core.reg_write_sel = 2'd2;
        end
        default: ;
      endcase
    end
  end

  assign done     = (state_q == S_DONE);
  assign timeout  = timeout_q;
  assign diverged = diverged_q;
  assign pc       = pc_q;

  always_comb begin
    instr_d    = instr_q;
    pc_d       = pc_q;
    nzp_d      = nzp_q;
    wd_d       = wd_q;
    timeout_d  = timeout_q;
    diverged_d = diverged_q;
    if (state_q == S_IDLE) begin
      if (start) begin
        pc_d       = '0;
        wd_d       = '0;
        timeout_d  = 1'b0;
        diverged_d = 1'b0;
      end
    end else if (running) begin
      if (wd_q < WD_LIMIT) wd_d = wd_q + WD_W'(1);
      if (expired) begin
        timeout_d = 1'b1;
      end else begin
        case (state_q)
          S_DECODE: begin
            instr_d.alu    = core.is_alu;
            instr_d.cmp    = core.is_cmp;
            instr_d.cnst   = core.is_const;
            instr_d.ldr    = core.is_ldr;
            instr_d.str    = core.is_str;
            instr_d.branch = core.is_branch;
            instr_d.cond   = core.condition;
            instr_d.target = core.branch_target;
          end
          S_EXECUTE: begin
            if (instr_q.cmp) begin
              for (int t = 0; t < T; t++) begin
                if (active_threads[t]) nzp_d[t] = core.alu_nzp[3*t +: 3];
              end
            end
          end
          S_UPDATE: begin
            pc_d = pc_q + A'(1);
            if (instr_q.branch) begin
              if (branch_take)       pc_d       = instr_q.target;
              else if (branch_mixed) diverged_d = 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // NOTE: the NZP flags are a handful of flops, so they are reset with the rest of the state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      instr_q    <= '0;
      pc_q       <= '0;
      nzp_q      <= '0;
      wd_q       <= '0;
      timeout_q  <= 1'b0;
      diverged_q <= 1'b0;
    end else begin
      instr_q    <= instr_d;
      pc_q       <= pc_d;
      nzp_q      <= nzp_d;
      wd_q       <= wd_d;
      timeout_q  <= timeout_d;
      diverged_q <= diverged_d;
    end
  end
endmodule

// File: tb/tb_simt_core_sequencer.sv
// Scoreboard bench: a program-level model predicts memory requests, register writes and the
// final done record; a monitor compares them as the sequencer presents them.
module tb_simt_core_sequencer;
  localparam int T    = 4;
  localparam int A    = 8;
  localparam int WD   = 30;
  localparam int TC_W = $clog2(T) + 1;
  localparam int NZ_W = 3 * T;

  logic            clk = 1'b0;
  logic            reset;
  logic            start;
  logic [TC_W-1:0] thread_count;
  logic            done, timeout, diverged;
  logic [T-1:0]    active_threads;
  logic [A-1:0]    pc;

  simt_core_sequencer_if #(.THREADS_PER_BLOCK(T), .PROGRAM_MEM_ADDR_BITS(A)) bus ();

  simt_core_sequencer #(
    .THREADS_PER_BLOCK(T), .PROGRAM_MEM_ADDR_BITS(A), .WATCHDOG_CYCLES(WD)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .thread_count(thread_count),
    .done(done), .timeout(timeout), .diverged(diverged),
    .active_threads(active_threads), .pc(pc), .core(bus)
  );

  always #5 clk = ~clk;

  typedef enum int {OP_NOP, OP_ALU, OP_CMP, OP_CONST, OP_LDR, OP_STR, OP_BR, OP_HALT} op_e;
  typedef struct { op_e op; logic [2:0] cond; logic [A-1:0] target; logic [NZ_W-1:0] nzp; } instr_t;
  typedef struct { logic [T-1:0] ld; logic [T-1:0] st; int len; } mem_ev_t;
  typedef struct { logic [T-1:0] mask; logic [1:0] sel; } wr_ev_t;
  typedef struct { logic [A-1:0] pc; logic to; logic dv; int lat; } done_ev_t;

  instr_t   prog [256];
  mem_ev_t  mem_q [$];
  wr_ev_t   wr_q [$];
  done_ev_t done_q [$];
  done_ev_t m_last;
  logic [2:0] m_nzp [T];

  int n_checks = 0, n_pass = 0;
  int fetch_delay = 0;
  int lsu_delay [T];
  int cyc = 0, start_cyc = 0;
  int obs_lat = 0, obs_mem_len = 0;
  bit mon_en = 1'b0, done_seen = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  function automatic logic [T-1:0] lane_mask(input int tc);
    logic [T-1:0] m = '0;
    for (int i = 0; i < T; i++) if (i < tc) m[i] = 1'b1;
    return m;
  endfunction

  // Walks the program one instruction at a time, placing each phase on an active-cycle
  // timeline; anything landing at or beyond cycle WD is lost to the watchdog.
  task automatic model_run(input int tc);
    logic [T-1:0] mask;
    logic [A-1:0] p;
    logic         dv;
    int           t, d, m, len, e, u;
    bit           fin;
    instr_t       ins;
    done_ev_t     dn;
    mem_ev_t      me;
    wr_ev_t       we;
    logic [T-1:0] agree;
    mask = lane_mask(tc);
    p = '0; dv = 1'b0; t = 0; fin = 1'b0;
    while (1) begin
      ins = prog[p];
      d = t + fetch_delay + 1;
      if (d >= WD) break;
      if (ins.op == OP_HALT) begin
        dn.pc = p; dn.to = 1'b0; dn.dv = dv; dn.lat = d + 1; fin = 1'b1;
        break;
      end
      e = d + 1;
      if (ins.op == OP_LDR || ins.op == OP_STR) begin
        m = d + 1;
        if (m >= WD) break;
        len = 1;
        for (int i = 0; i < T; i++) if (mask[i] && lsu_delay[i] + 1 > len) len = lsu_delay[i] + 1;
        if (mask != '0) begin
          me.ld  = (ins.op == OP_LDR) ? mask : '0;
          me.st  = (ins.op == OP_STR) ? mask : '0;
          me.len = (len < WD - m) ? len : WD - m;
          mem_q.push_back(me);
        end
        e = m + len;
      end
      if (e >= WD) break;
      if (mask != '0 && (ins.op == OP_ALU || ins.op == OP_CONST || ins.op == OP_LDR)) begin
        we.mask = mask;
        we.sel  = (ins.op == OP_LDR) ? 2'd1 : (ins.op == OP_CONST) ? 2'd2 : 2'd0;
        wr_q.push_back(we);
      end
      if (ins.op == OP_CMP)
        for (int i = 0; i < T; i++) if (mask[i]) m_nzp[i] = ins.nzp[3*i +: 3];
      u = e + 1;
      if (u >= WD) break;
      if (ins.op == OP_BR) begin
        agree = '0;
        for (int i = 0; i < T; i++) if (mask[i] && (m_nzp[i] & ins.cond) != 3'b000) agree[i] = 1'b1;
        if (mask != '0 && agree == mask) p = ins.target;
        else begin
          p = p + 1'b1;
          if (agree != '0) dv = 1'b1;
        end
      end else begin
        p = p + 1'b1;
      end
      t = u + 1;
    end
    if (!fin) begin
      dn.pc = p; dn.to = 1'b1; dn.dv = dv; dn.lat = WD + 1;
    end
    m_last = dn;
    done_q.push_back(dn);
  endtask

  // Fetch unit, decoder and LSU stand-ins.
  initial begin : env
    int     fcnt;
    int     lcnt [T];
    instr_t ins;
    fcnt = 0;
    for (int i = 0; i < T; i++) lcnt[i] = 0;
    bus.fetch_done = 1'b0; bus.is_alu = 1'b0; bus.is_cmp = 1'b0; bus.is_const = 1'b0;
    bus.is_ldr = 1'b0; bus.is_str = 1'b0; bus.is_branch = 1'b0; bus.is_halt = 1'b0;
    bus.condition = '0; bus.branch_target = '0; bus.alu_nzp = '0; bus.lsu_done = '0;
    forever begin
      @(negedge clk);
      if (bus.fetch_enable) begin
        if (fcnt >= fetch_delay) begin
          ins = prog[pc];
          bus.fetch_done    = 1'b1;
          bus.is_alu        = (ins.op == OP_ALU);
          bus.is_cmp        = (ins.op == OP_CMP);
          bus.is_const      = (ins.op == OP_CONST);
          bus.is_ldr        = (ins.op == OP_LDR);
          bus.is_str        = (ins.op == OP_STR);
          bus.is_branch     = (ins.op == OP_BR);
          bus.is_halt       = (ins.op == OP_HALT);
          bus.condition     = ins.cond;
          bus.branch_target = ins.target;
          bus.alu_nzp       = ins.nzp;
        end else begin
          bus.fetch_done = 1'b0;
          fcnt++;
        end
      end else begin
        fcnt = 0;
        bus.fetch_done = 1'b0;
      end
      for (int i = 0; i < T; i++) begin
        if (bus.lsu_load_enable[i] || bus.lsu_store_enable[i]) begin
          if (lcnt[i] >= lsu_delay[i]) bus.lsu_done[i] = 1'b1;
          else begin
            bus.lsu_done[i] = 1'b0;
            lcnt[i]++;
          end
        end else begin
          lcnt[i] = 0;
          bus.lsu_done[i] = 1'($urandom_range(0, 1));
        end
      end
    end
  end

  initial begin : monitor
    logic [T-1:0] mld, mst;
    int           mlen;
    bit           in_mem, done_prev;
    mem_ev_t      me;
    wr_ev_t       we;
    done_ev_t     de;
    in_mem = 1'b0; done_prev = 1'b0; mlen = 0; mld = '0; mst = '0;
    forever begin
      @(negedge clk);
      if (!mon_en) begin
        in_mem = 1'b0;
        done_prev = done;
        continue;
      end
      if (bus.reg_write_enable != '0) begin
        if (wr_q.size() == 0) check("unexpected_write", bus.reg_write_enable, 0);
        else begin
          we = wr_q.pop_front();
          check("write_mask", bus.reg_write_enable, we.mask);
          check("write_sel", bus.reg_write_sel, we.sel);
        end
      end
      if ((bus.lsu_load_enable | bus.lsu_store_enable) != '0) begin
        if (!in_mem) begin
          in_mem = 1'b1; mld = bus.lsu_load_enable; mst = bus.lsu_store_enable; mlen = 0;
        end
        mlen++;
      end else if (in_mem) begin
        in_mem = 1'b0;
        obs_mem_len = mlen;
        if (mem_q.size() == 0) check("unexpected_mem", mlen, 0);
        else begin
          me = mem_q.pop_front();
          check("mem_load_mask", mld, me.ld);
          check("mem_store_mask", mst, me.st);
          check("mem_len", mlen, me.len);
        end
      end
      if (done && !done_prev) begin
        obs_lat = cyc - start_cyc;
        if (done_q.size() == 0) check("unexpected_done", done, 0);
        else begin
          de = done_q.pop_front();
          check("done_pc", pc, de.pc);
          check("done_timeout", timeout, de.to);
          check("done_diverged", diverged, de.dv);
          check("done_latency", obs_lat, de.lat);
        end
        done_seen = 1'b1;
      end
      done_prev = done;
    end
  end

  task automatic clear_prog();
    for (int i = 0; i < 256; i++) begin
      prog[i].op = OP_HALT; prog[i].cond = '0; prog[i].target = '0; prog[i].nzp = '0;
    end
  endtask

  task automatic set_ins(input int addr, input op_e op, input logic [2:0] cond,
                         input logic [A-1:0] target, input logic [NZ_W-1:0] nzp);
    prog[addr].op = op; prog[addr].cond = cond; prog[addr].target = target; prog[addr].nzp = nzp;
  endtask

  task automatic run_test(input int tc);
    thread_count = TC_W'(tc);
    #1;
    check("active_threads", active_threads, lane_mask(tc));
    model_run(tc);
    mon_en = 1'b1;
    done_seen = 1'b0;
    @(negedge clk);
    start = 1'b1;
    start_cyc = cyc + 1;
    for (int i = 0; i < 200 && !done_seen; i++) @(negedge clk);
    check("done_reached", done_seen, 1);
    repeat (2) @(negedge clk);
    check("done_hold", done, 1);
    start = 1'b0;
    @(posedge clk);
    #1;
    check("done_clear", done, 0);
    check("pc_hold", pc, m_last.pc);
    check("timeout_sticky", timeout, m_last.to);
    check("diverged_sticky", diverged, m_last.dv);
    check("scoreboard_empty", wr_q.size() + mem_q.size() + done_q.size(), 0);
    @(negedge clk);
  endtask

  initial begin : global_guard
    #2000000;
    $display("FAIL global_guard: simulation did not finish in time");
    $fatal(1, "global guard expired");
  end

  initial begin : main
    for (int i = 0; i < T; i++) begin
      m_nzp[i] = 3'b000;
      lsu_delay[i] = 0;
    end
    reset = 1'b1;
    start = 1'b0;
    thread_count = '0;
    clear_prog();
    #1;
    check("rst_done", done, 0);
    check("rst_timeout", timeout, 0);
    check("rst_diverged", diverged, 0);
    check("rst_pc", pc, 0);
    check("rst_fetch_enable", bus.fetch_enable, 0);
    check("rst_reg_write", {bus.reg_write_enable, bus.reg_write_sel}, 0);
    check("rst_lsu", {bus.lsu_load_enable, bus.lsu_store_enable}, 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // 1: CONST, ADD, HALT with two-cycle fetch
    clear_prog();
    fetch_delay = 1;
    set_ins(0, OP_CONST, 3'b000, 8'h00, '0);
    set_ins(1, OP_ALU,   3'b000, 8'h00, '0);
    run_test(4);
    check("t1_latency", obs_lat, 13);
    check("t1_pc", pc, 2);

    // 2: LDR with staggered lane completion
    clear_prog();
    fetch_delay = 1;
    lsu_delay[0] = 1; lsu_delay[1] = 5; lsu_delay[2] = 0; lsu_delay[3] = 0;
    set_ins(0, OP_LDR, 3'b000, 8'h00, '0);
    run_test(2);
    check("t2_mem_len", obs_mem_len, 6);

    // 3: uniform branch taken, then divergent branch
    clear_prog();
    fetch_delay = 0;
    set_ins(0, OP_CMP, 3'b000, 8'h00, {4{3'b010}});
    set_ins(1, OP_BR,  3'b010, 8'h10, '0);
    run_test(4);
    check("t3_taken_pc", pc, 8'h10);
    set_ins(0, OP_CMP, 3'b000, 8'h00, {3'b010, 3'b010, 3'b001, 3'b010});
    run_test(4);
    check("t3_diverged", diverged, 1);
    check("t3_fallthrough_pc", pc, 2);

    // 4: empty mask, STR then unconditional branch
    clear_prog();
    fetch_delay = 1;
    set_ins(0, OP_STR, 3'b000, 8'h00, '0);
    set_ins(1, OP_BR,  3'b111, 8'h20, '0);
    run_test(0);
    check("t4_pc", pc, 2);

    // 5: infinite loop ends in watchdog timeout
    clear_prog();
    fetch_delay = 0;
    set_ins(0, OP_CMP, 3'b000, 8'h00, {4{3'b100}});
    set_ins(1, OP_BR,  3'b111, 8'h00, '0);
    run_test(4);
    check("t5_timeout", timeout, 1);

    // 6: reset during a pending memory wait
    clear_prog();
    for (int i = 0; i < T; i++) lsu_delay[i] = 6;
    set_ins(0, OP_LDR, 3'b000, 8'h00, '0);
    thread_count = TC_W'(4);
    mon_en = 1'b0;
    @(negedge clk);
    start = 1'b1;
    for (int i = 0; i < 50 && bus.lsu_load_enable == '0; i++) @(negedge clk);
    check("t6_mem_reached", bus.lsu_load_enable, 4'hF);
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("t6_lsu", {bus.lsu_load_enable, bus.lsu_store_enable}, 0);
    check("t6_fetch", bus.fetch_enable, 0);
    check("t6_write", {bus.reg_write_enable, bus.reg_write_sel}, 0);
    check("t6_status", {done, timeout, diverged}, 0);
    check("t6_pc", pc, 0);
    @(negedge clk);
    reset = 1'b0;
    start = 1'b0;
    wr_q.delete(); mem_q.delete(); done_q.delete();
    for (int i = 0; i < T; i++) m_nzp[i] = 3'b000;
    @(negedge clk);
    clear_prog();
    for (int i = 0; i < T; i++) lsu_delay[i] = 1;
    set_ins(0, OP_CONST, 3'b000, 8'h00, '0);
    set_ins(1, OP_LDR,   3'b000, 8'h00, '0);
    run_test(3);

    // Randomized programs
    for (int r = 0; r < 30; r++) begin
      clear_prog();
      for (int k = 0; k < int'($urandom_range(1, 5)); k++)
        set_ins(k, op_e'($urandom_range(0, 7)), 3'($urandom), A'($urandom_range(0, 7)), NZ_W'($urandom));
      fetch_delay = $urandom_range(0, 2);
      for (int i = 0; i < T; i++) lsu_delay[i] = $urandom_range(0, 3);
      run_test($urandom_range(0, 7));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
